// File: rtl/l2_cache_nway.sv
`timescale 1ns/1ps
// l2_cache_nway: N-way set-associative, write-back, write-allocate L2 cache
// with tree-PLRU replacement and a software flush walk that cleans every dirty line.
module l2_cache_nway #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int num_ways = 4,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mem_read,
    input  logic                          mem_write,
    input  logic [3:0]                    mem_byte_enable,
    input  logic [31:0]                   mem_address,
    input  logic [31:0]                   mem_wdata,
    output logic                          mem_resp,
    output logic [31:0]                   mem_rdata,
    input  logic                          flush,
    output logic                          flush_done,
    input  logic                          pmem_resp,
    input  logic [2**(s_offset+3)-1:0]    pmem_rdata,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [31:0]                   pmem_address,
    output logic [2**(s_offset+3)-1:0]    pmem_wdata
);
    localparam int LINE     = 2**(s_offset+3);
    localparam int NUM_SETS = 2**s_index;
    localparam int WAYBITS  = $clog2(num_ways);
    localparam int WORDBITS = s_offset - 2;
    localparam int CNTBITS  = s_index + WAYBITS + 1;

    typedef enum logic [2:0] {CHECK, WRITEBACK, FILL, FLUSH, FLUSH_WB} state_t;

    state_t               r_state;
    logic                 r_valid [NUM_SETS][num_ways];
    logic                 r_dirty [NUM_SETS][num_ways];
    logic [s_tag-1:0]     r_tag   [NUM_SETS][num_ways];
    logic [LINE-1:0]      r_data  [NUM_SETS][num_ways];
    logic [num_ways-2:0]  r_plru  [NUM_SETS];
    logic [WAYBITS-1:0]   r_victim;
    logic [s_tag-1:0]     r_reqTag;
    logic [s_index-1:0]   r_reqIndex;
    logic [CNTBITS-1:0]   r_flushCnt;
    logic                 r_pmemRead;
    logic                 r_pmemWrite;
    logic [31:0]          r_pmemAddr;
    logic [LINE-1:0]      r_pmemWdata;
    logic                 r_flushDone;

    logic                 w_req;
    logic [s_tag-1:0]     w_tag;
    logic [s_index-1:0]   w_index;
    logic [WORDBITS-1:0]  w_word;
    logic                 w_hit;
    logic [WAYBITS-1:0]   w_hitWay;
    logic [WAYBITS-1:0]   w_victim;
    logic                 w_foundInvalid;
    logic [LINE-1:0]      w_hitLine;
    logic [LINE-1:0]      w_mergedLine;
    logic [31:0]          w_hitWord;
    logic [s_index-1:0]   w_flushSet;
    logic [WAYBITS-1:0]   w_flushWay;
    logic                 w_flushEnd;
    logic                 w_unusedAddrBits;

    // Walk the PLRU tree from the root; a node bit of 0 sends the victim to the lower half.
    function automatic logic [WAYBITS-1:0] plruVictim(input logic [num_ways-2:0] bits);
        logic [WAYBITS-1:0] way;
        int                 node;
        way  = '0;
        node = 0;
        for (int l = 0; l < WAYBITS; l++) begin
            way[WAYBITS-1-l] = bits[node];
            node = 2 * node + 1 + int'(bits[node]);
        end
        return way;
    endfunction

    // Point every node on the accessed way's path away from that way.
    function automatic logic [num_ways-2:0] plruTouch(input logic [num_ways-2:0] bits,
                                                     input logic [WAYBITS-1:0] way);
        logic [num_ways-2:0] nodeBits;
        logic                dir;
        int                  node;
        nodeBits = bits;
        node     = 0;
        for (int l = 0; l < WAYBITS; l++) begin
            dir            = way[WAYBITS-1-l];
            nodeBits[node] = ~dir;
            node           = 2 * node + 1 + int'(dir);
        end
        return nodeBits;
    endfunction

    assign w_req            = mem_read | mem_write;
    assign w_tag            = mem_address[31 -: s_tag];
    assign w_index          = mem_address[s_offset +: s_index];
    assign w_word           = mem_address[2 +: WORDBITS];
    assign w_unusedAddrBits = ^mem_address[1:0];
    assign w_flushSet       = r_flushCnt[WAYBITS +: s_index];
    assign w_flushWay       = r_flushCnt[WAYBITS-1:0];
    assign w_flushEnd       = r_flushCnt[CNTBITS-1];

    // Tag compare across all ways of the addressed set.
    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < num_ways; w++) begin
            if (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = WAYBITS'(w);
            end
        end
    end

    // Victim choice: lowest invalid way first, otherwise whatever the PLRU tree names.
    always_comb begin
        w_victim       = plruVictim(r_plru[w_index]);
        w_foundInvalid = 1'b0;
        for (int w = 0; w < num_ways; w++) begin
            if (!w_foundInvalid && !r_valid[w_index][w]) begin
                w_victim       = WAYBITS'(w);
                w_foundInvalid = 1'b1;
            end
        end
    end

    // Hit word extraction and byte-lane merge of the write data into the hit line.
    always_comb begin
        w_hitLine    = r_data[w_index][w_hitWay];
        w_hitWord    = w_hitLine[32 * int'(w_word) +: 32];
        w_mergedLine = w_hitLine;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                w_mergedLine[32 * int'(w_word) + 8 * b +: 8] = mem_wdata[8 * b +: 8];
            end
        end
    end

    assign mem_resp     = (r_state == CHECK) && w_req && w_hit;
    assign mem_rdata    = mem_resp ? w_hitWord : 32'b0;
    assign flush_done   = r_flushDone;
    assign pmem_read    = r_pmemRead;
    assign pmem_write   = r_pmemWrite;
    assign pmem_address = r_pmemAddr;
    assign pmem_wdata   = r_pmemWdata;

    // Controller, cache arrays and registered memory-side strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CHECK;
            r_victim    <= '0;
            r_reqTag    <= '0;
            r_reqIndex  <= '0;
            r_flushCnt  <= '0;
            r_pmemRead  <= 1'b0;
            r_pmemWrite <= 1'b0;
            r_pmemAddr  <= '0;
            r_pmemWdata <= '0;
            r_flushDone <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_plru[s] <= '0;
                for (int w = 0; w < num_ways; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            r_flushDone <= 1'b0;
            case (r_state)
                CHECK: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_plru[w_index] <= plruTouch(r_plru[w_index], w_hitWay);
                            if (mem_write) begin
                                r_data[w_index][w_hitWay]  <= w_mergedLine;
                                r_dirty[w_index][w_hitWay] <= 1'b1;
                            end
                        end else begin
                            r_victim   <= w_victim;
                            r_reqTag   <= w_tag;
                            r_reqIndex <= w_index;
                            if (r_valid[w_index][w_victim] && r_dirty[w_index][w_victim]) begin
                                r_state     <= WRITEBACK;
                                r_pmemWrite <= 1'b1;
                                r_pmemAddr  <= {r_tag[w_index][w_victim], w_index, {s_offset{1'b0}}};
                                r_pmemWdata <= r_data[w_index][w_victim];
                            end else begin
                                r_state    <= FILL;
                                r_pmemRead <= 1'b1;
                                r_pmemAddr <= {w_tag, w_index, {s_offset{1'b0}}};
                            end
                        end
                    end else if (flush) begin
                        r_state    <= FLUSH;
                        r_flushCnt <= '0;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        r_state     <= FILL;
                        r_pmemWrite <= 1'b0;
                        r_pmemWdata <= '0;
                        r_pmemRead  <= 1'b1;
                        r_pmemAddr  <= {r_reqTag, r_reqIndex, {s_offset{1'b0}}};
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        r_data[r_reqIndex][r_victim]  <= pmem_rdata;
                        r_tag[r_reqIndex][r_victim]   <= r_reqTag;
                        r_valid[r_reqIndex][r_victim] <= 1'b1;
                        r_dirty[r_reqIndex][r_victim] <= 1'b0;
                        r_pmemRead                    <= 1'b0;
                        r_pmemAddr                    <= '0;
                        r_state                       <= CHECK;
                    end
                end
                FLUSH: begin
                    if (w_flushEnd) begin
                        r_flushDone <= 1'b1;
                        r_state     <= CHECK;
                    end else if (r_valid[w_flushSet][w_flushWay] && r_dirty[w_flushSet][w_flushWay]) begin
                        r_state     <= FLUSH_WB;
                        r_pmemWrite <= 1'b1;
                        r_pmemAddr  <= {r_tag[w_flushSet][w_flushWay], w_flushSet, {s_offset{1'b0}}};
                        r_pmemWdata <= r_data[w_flushSet][w_flushWay];
                    end else begin
                        r_flushCnt <= r_flushCnt + 1'b1;
                    end
                end
                FLUSH_WB: begin
                    if (pmem_resp) begin
                        r_dirty[w_flushSet][w_flushWay] <= 1'b0;
                        r_pmemWrite                     <= 1'b0;
                        r_pmemAddr                      <= '0;
                        r_pmemWdata                     <= '0;
                        r_flushCnt                      <= r_flushCnt + 1'b1;
                        r_state                         <= FLUSH;
                    end
                end
                default: r_state <= CHECK;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_cache_nway.sv
`timescale 1ns/1ps
// tb_l2_cache_nway: directed scenarios plus a randomized run of the default
// 8-set, 4-way cache against a flat-memory / set-state reference model.
module tb_l2_cache_nway;
    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [255:0] d;
    } pev_t;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic         mem_resp;
    logic [31:0]  mem_rdata;
    logic         flush;
    logic         flush_done;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    // Backing store seen by the responder, and the bench's own expectation of memory.
    logic [255:0] mainMem [512];
    logic [255:0] expMem  [512];
    logic [31:0]  shadow  [4096];
    bit           mValid  [8][4];
    bit           mDirty  [8][4];
    int           mTag    [8][4];
    bit           mPlru   [8][3];

    pev_t         evLog[$];
    pev_t         lastEvents[$];
    pev_t         respEv;
    bit           lastHit;
    logic [31:0]  lastRdata;
    bit           respEnable   = 1'b1;
    bit           conflictSeen = 1'b0;
    int           waitCnt      = 0;

    l2_cache_nway dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .flush           (flush),
        .flush_done      (flush_done),
        .pmem_resp       (pmem_resp),
        .pmem_rdata      (pmem_rdata),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the cache wedges somewhere no bounded wait covers.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    // Line-memory responder with a random 0..3 cycle latency; logs every transfer.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write) conflictSeen = 1'b1;
            if (!rst && respEnable && (pmem_read || pmem_write)) begin
                if (waitCnt == 0) begin
                    respEv.w = pmem_write;
                    respEv.a = pmem_address;
                    if (pmem_write) begin
                        respEv.d = pmem_wdata;
                        mainMem[int'(pmem_address[13:5])] = pmem_wdata;
                    end else begin
                        respEv.d   = '0;
                        pmem_rdata = mainMem[int'(pmem_address[13:5])];
                    end
                    evLog.push_back(respEv);
                    pmem_resp = 1'b1;
                    waitCnt   = $urandom_range(0, 3);
                end else begin
                    waitCnt--;
                end
            end
        end
    end

    function automatic logic [255:0] shadowLine(input logic [31:0] lineAddr);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = shadow[int'(lineAddr[13:5]) * 8 + i];
        return l;
    endfunction

    function automatic int modelVictim(input int set);
        int lo, span, node, half;
        for (int w = 0; w < 4; w++) if (!mValid[set][w]) return w;
        lo = 0; span = 4; node = 0;
        while (span > 1) begin
            half = span / 2;
            if (mPlru[set][node] == 1'b0) node = 2 * node + 1;
            else begin lo += half; node = 2 * node + 2; end
            span = half;
        end
        return lo;
    endfunction

    task automatic modelTouch(input int set, input int way);
        int lo, span, node, half;
        lo = 0; span = 4; node = 0;
        while (span > 1) begin
            half = span / 2;
            if (way < lo + half) begin mPlru[set][node] = 1'b1; node = 2 * node + 1; end
            else begin mPlru[set][node] = 1'b0; lo += half; node = 2 * node + 2; end
            span = half;
        end
    endtask

    task automatic modelReset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 4; w++) begin mValid[s][w] = 0; mDirty[s][w] = 0; end
            for (int n = 0; n < 3; n++) mPlru[s][n] = 0;
        end
        for (int i = 0; i < 512; i++)
            for (int j = 0; j < 8; j++) shadow[i * 8 + j] = expMem[i][j*32 +: 32];
    endtask

    task automatic setWord(input logic [31:0] addr, input logic [31:0] val);
        mainMem[int'(addr[13:5])][32 * int'(addr[4:2]) +: 32] = val;
        expMem[int'(addr[13:5])][32 * int'(addr[4:2]) +: 32]  = val;
        shadow[int'(addr[13:2])] = val;
    endtask

    task automatic compareEvents(input pev_t expEv[$]);
        checkOutput("pmemCount", evLog.size(), expEv.size());
        for (int i = 0; i < evLog.size() && i < expEv.size(); i++) begin
            checkOutput("pmemKind", evLog[i].w, expEv[i].w);
            checkOutput("pmemAddr", evLog[i].a, expEv[i].a);
            if (expEv[i].w) checkOutput("pmemWdata", evLog[i].d, expEv[i].d);
        end
        lastEvents = evLog;
    endtask

    function automatic logic [31:0] evAddr(input int idx);
        return (idx < lastEvents.size()) ? lastEvents[idx].a : 32'hFFFF_FFFF;
    endfunction

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; mem_read = 0; mem_write = 0; flush = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    // One CPU access; expectations come from the model before the request is issued.
    task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        int          set, way, cycles;
        bit          expHit, got;
        pev_t        expEv[$];
        pev_t        e;
        logic [31:0] expWord, rdata, lineAddr;
        set = int'(addr[7:5]);
        lineAddr = {addr[31:5], 5'b0};
        expHit = 0; way = 0; rdata = '0;
        for (int w = 0; w < 4; w++)
            if (mValid[set][w] && mTag[set][w] == int'(addr[31:8])) begin expHit = 1; way = w; end
        if (!expHit) begin
            way = modelVictim(set);
            if (mValid[set][way] && mDirty[set][way]) begin
                e.w = 1;
                e.a = (32'(mTag[set][way]) << 8) | (32'(set) << 5);
                e.d = shadowLine(e.a);
                expMem[int'(e.a[13:5])] = e.d;
                expEv.push_back(e);
            end
            e.w = 0; e.a = lineAddr; e.d = '0;
            expEv.push_back(e);
            mValid[set][way] = 1; mDirty[set][way] = 0; mTag[set][way] = int'(addr[31:8]);
        end
        modelTouch(set, way);
        expWord = shadow[int'(addr[13:2])];
        if (isWrite) begin
            mDirty[set][way] = 1;
            for (int b = 0; b < 4; b++)
                if (be[b]) shadow[int'(addr[13:2])][8*b +: 8] = wdata[8*b +: 8];
        end

        evLog.delete();
        @(negedge clk);
        mem_read = !isWrite; mem_write = isWrite; mem_address = addr;
        mem_byte_enable = be; mem_wdata = wdata;
        cycles = 0; got = 0;
        while (!got && cycles < 500) begin
            #1;
            if (mem_resp) begin got = 1; rdata = mem_rdata; end
            else begin @(negedge clk); cycles++; end
        end
        @(posedge clk);
        #1;
        mem_read = 0; mem_write = 0;
        lastHit = got && (cycles == 0);
        lastRdata = rdata;
        checkOutput("respSeen", got, 1'b1);
        if (got) begin
            checkOutput("hitMiss", cycles == 0, expHit);
            if (!isWrite) checkOutput("rdata", rdata, expWord);
            compareEvents(expEv);
        end
    endtask

    // Software flush: expected writebacks are every model-dirty slot in set-major order.
    task automatic flushStimulus();
        pev_t expEv[$];
        pev_t e;
        int   cycles;
        bit   seen;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++)
                if (mValid[s][w] && mDirty[s][w]) begin
                    e.w = 1;
                    e.a = (32'(mTag[s][w]) << 8) | (32'(s) << 5);
                    e.d = shadowLine(e.a);
                    expMem[int'(e.a[13:5])] = e.d;
                    expEv.push_back(e);
                    mDirty[s][w] = 0;
                end
        evLog.delete();
        @(negedge clk);
        flush = 1'b1;
        cycles = 0; seen = 0;
        while (!seen && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (flush_done) seen = 1;
        end
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flushDone", seen, 1'b1);
        checkOutput("flushDonePulse", flush_done, 1'b0);
        compareEvents(expEv);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "MemResp"}, mem_resp, 1'b0);
        checkOutput({tag, "Rdata"}, mem_rdata, 32'h0);
        checkOutput({tag, "PmemRead"}, pmem_read, 1'b0);
        checkOutput({tag, "PmemWrite"}, pmem_write, 1'b0);
        checkOutput({tag, "PmemAddr"}, pmem_address, 32'h0);
        checkOutput({tag, "PmemWdata"}, pmem_wdata, 256'h0);
        checkOutput({tag, "FlushDone"}, flush_done, 1'b0);
    endtask

    // Main sequence: directed scenarios, then randomized traffic with occasional flushes.
    initial begin
        int          writeCount;
        int          cycles;
        logic [2:0]  rTag, rSet, rWord;
        rst = 1'b1; mem_read = 0; mem_write = 0; flush = 0;
        mem_byte_enable = '0; mem_address = '0; mem_wdata = '0;
        for (int i = 0; i < 512; i++) begin
            for (int j = 0; j < 8; j++) mainMem[i][j*32 +: 32] = $urandom;
            expMem[i] = mainMem[i];
        end
        setWord(32'h0000_1004, 32'hDEAD_BEEF);
        doReset();
        checkIdle("reset");

        applyStimulus(0, 32'h0000_1004, 4'h0, 32'h0);
        checkOutput("t1MissRdata", lastRdata, 32'hDEAD_BEEF);
        checkOutput("t1MissFlag", lastHit, 1'b0);
        checkOutput("t1FillAddr", evAddr(0), 32'h0000_1000);
        applyStimulus(0, 32'h0000_1004, 4'h0, 32'h0);
        checkOutput("t1ReHit", lastHit, 1'b1);

        applyStimulus(1, 32'h0000_1004, 4'b0011, 32'h1234_5678);
        checkOutput("t2WriteHit", lastHit, 1'b1);
        applyStimulus(0, 32'h0000_1004, 4'h0, 32'h0);
        checkOutput("t2Merged", lastRdata, 32'hDEAD_5678);

        doReset();
        applyStimulus(0, 32'h0000_0000, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0100, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0200, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0300, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0000, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0400, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0300, 4'h0, 32'h0);
        checkOutput("t3KeepWay3", lastHit, 1'b1);
        applyStimulus(0, 32'h0000_0200, 4'h0, 32'h0);
        checkOutput("t3Evicted", lastHit, 1'b0);

        doReset();
        applyStimulus(1, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5);
        applyStimulus(0, 32'h0000_0100, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0200, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0300, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0400, 4'h0, 32'h0);
        checkOutput("t4WbKind", (lastEvents.size() > 0) ? lastEvents[0].w : 1'b0, 1'b1);
        checkOutput("t4WbAddr", evAddr(0), 32'h0000_0000);
        checkOutput("t4WbWord0", (lastEvents.size() > 0) ? lastEvents[0].d[31:0] : 32'h0, 32'hA5A5_A5A5);
        checkOutput("t4FillAddr", evAddr(1), 32'h0000_0400);

        doReset();
        applyStimulus(1, 32'h0000_0020, 4'hF, 32'h1111_2222);
        applyStimulus(1, 32'h0000_00A0, 4'hF, 32'h3333_4444);
        flushStimulus();
        checkOutput("t5WbCount", lastEvents.size(), 2);
        checkOutput("t5FirstAddr", evAddr(0), 32'h0000_0020);
        checkOutput("t5SecondAddr", evAddr(1), 32'h0000_00A0);
        writeCount = 0;
        applyStimulus(0, 32'h0000_0120, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0220, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0320, 4'h0, 32'h0);
        applyStimulus(0, 32'h0000_0420, 4'h0, 32'h0);
        foreach (lastEvents[i]) if (lastEvents[i].w) writeCount++;
        checkOutput("t5CleanEvict", writeCount, 0);

        doReset();
        applyStimulus(0, 32'h0000_1004, 4'h0, 32'h0);
        respEnable = 1'b0;
        @(negedge clk);
        mem_read = 1'b1; mem_address = 32'h0000_2004;
        cycles = 0;
        while (!pmem_read && cycles < 20) begin @(negedge clk); cycles++; end
        checkOutput("t6FillStarted", pmem_read, 1'b1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        checkOutput("t6RstPmemRead", pmem_read, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        respEnable = 1'b1;
        modelReset();
        applyStimulus(0, 32'h0000_1004, 4'h0, 32'h0);
        checkOutput("t6MissAfterRst", lastHit, 1'b0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                flushStimulus();
            end else begin
                rTag = 3'($urandom_range(0, 7));
                rSet = 3'($urandom_range(0, 3));
                rWord = 3'($urandom_range(0, 7));
                applyStimulus(1'($urandom_range(0, 1)), {21'b0, rTag, rSet, rWord, 2'b00},
                              4'($urandom_range(0, 15)), $urandom);
            end
        end
        flushStimulus();
        checkOutput("pmemExclusive", conflictSeen, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
